// File: rtl/decode_hazard_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding unit.
package decode_hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // LL/SC reservation states
    typedef enum logic {
        HZ_IDLE     = 1'b0,
        HZ_RESERVED = 1'b1
    } hz_state_e;

    // One in-flight destination tag
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic                  is_load;
    } tag_entry_t;

    // A source matches a tag when the tag is live, names it, and it is not $zero
    function automatic logic src_match(input logic                  valid,
                                       input logic [REG_ADDR_W-1:0] tag_addr,
                                       input logic [REG_ADDR_W-1:0] src_addr);
        return valid && (tag_addr == src_addr) && (src_addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/decode_hazard_unit_if.sv
// Decode-side bus between the decode stage (master) and the hazard unit (slave).
interface decode_hazard_unit_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_STAGES = 3
);
    logic                         id_valid;
    logic [4:0]                   id_rs_addr;
    logic [4:0]                   id_rt_addr;
    logic                         id_reads_rs;
    logic                         id_reads_rt;
    logic                         id_reg_we;
    logic [4:0]                   id_reg_write_addr;
    logic                         id_is_load;
    logic                         id_is_ll;
    logic                         id_is_sc;
    logic                         id_is_store;
    logic [DATA_W-1:0]            rf_rs_data;
    logic [DATA_W-1:0]            rf_rt_data;
    logic [NUM_STAGES*DATA_W-1:0] stage_data;
    logic                         hold;
    logic                         flush;

    logic [DATA_W-1:0]            rs_data;
    logic [DATA_W-1:0]            rt_data;
    logic                         stall;
    logic                         issue;
    logic                         atomic_id;
    logic                         sc_mask_id;
    logic [NUM_STAGES-1:0]        occupancy;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_reads_rs, id_reads_rt,
               id_reg_we, id_reg_write_addr, id_is_load, id_is_ll, id_is_sc,
               id_is_store, rf_rs_data, rf_rt_data, stage_data, hold, flush,
        input  rs_data, rt_data, stall, issue, atomic_id, sc_mask_id, occupancy
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_reads_rs, id_reads_rt,
               id_reg_we, id_reg_write_addr, id_is_load, id_is_ll, id_is_sc,
               id_is_store, rf_rs_data, rf_rt_data, stage_data, hold, flush,
        output rs_data, rt_data, stall, issue, atomic_id, sc_mask_id, occupancy
    );

endinterface

// File: rtl/decode_hazard_unit_tag_pipe.sv
// Shift register of destination tags for the stages after decode (0 = EX).
module decode_hazard_unit_tag_pipe
    import decode_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_hold,
    input  logic                             i_flush,
    input  tag_entry_t                       i_push,
    output logic [NUM_STAGES-1:0]            o_valid,
    output logic [NUM_STAGES*REG_ADDR_W-1:0] o_addr,
    output logic [NUM_STAGES-1:0]            o_ready
);

    tag_entry_t r_entry [NUM_STAGES];

    // Advance tags one stage per edge; flush wins over hold, stalls push a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_entry[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_entry[i] <= '0;
            end
        end else if (!i_hold) begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                r_entry[i] <= r_entry[i-1];
            end
            r_entry[0] <= i_push;
        end
    end

    // Flatten entries; a load result only exists from stage LOAD_LAT onward
    always_comb begin
        o_valid = '0;
        o_addr  = '0;
        o_ready = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            o_valid[i]                       = r_entry[i].valid;
            o_addr[i*REG_ADDR_W +: REG_ADDR_W] = r_entry[i].addr;
            o_ready[i]                       = !r_entry[i].is_load || (i >= LOAD_LAT);
        end
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard detection, operand forwarding and LL/SC reservation.
module decode_hazard_unit
    import decode_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_unit_if.slave  io_bus
);

    logic [NUM_STAGES-1:0]            w_valid;
    logic [NUM_STAGES*REG_ADDR_W-1:0] w_addr;
    logic [NUM_STAGES-1:0]            w_ready;
    tag_entry_t                       w_push;

    logic              w_rs_hit;
    logic              w_rs_rdy;
    logic [DATA_W-1:0] w_rs_fwd;
    logic              w_rt_hit;
    logic              w_rt_rdy;
    logic [DATA_W-1:0] w_rt_fwd;
    logic              w_stall;
    logic              w_issue;

    hz_state_e r_state;
    hz_state_e w_state_next;

    decode_hazard_unit_tag_pipe #(
        .NUM_STAGES (NUM_STAGES),
        .LOAD_LAT   (LOAD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (io_bus.hold),
        .i_flush (io_bus.flush),
        .i_push  (w_push),
        .o_valid (w_valid),
        .o_addr  (w_addr),
        .o_ready (w_ready)
    );

    // Youngest matching stage wins: scan oldest to youngest so the lowest index lands last
    always_comb begin
        w_rs_hit = 1'b0;
        w_rs_rdy = 1'b1;
        w_rs_fwd = io_bus.rf_rs_data;
        w_rt_hit = 1'b0;
        w_rt_rdy = 1'b1;
        w_rt_fwd = io_bus.rf_rt_data;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (src_match(w_valid[i], w_addr[i*REG_ADDR_W +: REG_ADDR_W], io_bus.id_rs_addr)) begin
                w_rs_hit = 1'b1;
                w_rs_rdy = w_ready[i];
                w_rs_fwd = io_bus.stage_data[i*DATA_W +: DATA_W];
            end
            if (src_match(w_valid[i], w_addr[i*REG_ADDR_W +: REG_ADDR_W], io_bus.id_rt_addr)) begin
                w_rt_hit = 1'b1;
                w_rt_rdy = w_ready[i];
                w_rt_fwd = io_bus.stage_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stall on a consumed source whose youngest producer has no data yet
    always_comb begin
        w_stall = io_bus.id_valid &
                  ((io_bus.id_reads_rs & w_rs_hit & ~w_rs_rdy) |
                   (io_bus.id_reads_rt & w_rt_hit & ~w_rt_rdy));
        w_issue = io_bus.id_valid & ~w_stall & ~io_bus.hold & ~io_bus.flush;

        w_push         = '0;
        w_push.valid   = w_issue & io_bus.id_reg_we & (io_bus.id_reg_write_addr != REG_ZERO);
        w_push.addr    = io_bus.id_reg_write_addr;
        w_push.is_load = io_bus.id_is_load;
    end

    // Reservation next state; only an issued instruction can move it, LL wins
    always_comb begin
        w_state_next = r_state;
        if (w_issue) begin
            if (io_bus.id_is_ll) begin
                w_state_next = HZ_RESERVED;
            end else if (io_bus.id_is_store || io_bus.id_is_sc) begin
                w_state_next = HZ_IDLE;
            end
        end
    end

    // Reservation state register; flush drops the reservation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HZ_IDLE;
        end else if (io_bus.flush) begin
            r_state <= HZ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign io_bus.rs_data    = w_rs_fwd;
    assign io_bus.rt_data    = w_rt_fwd;
    assign io_bus.stall      = w_stall;
    assign io_bus.issue      = w_issue;
    assign io_bus.atomic_id  = (r_state == HZ_RESERVED);
    assign io_bus.sc_mask_id = io_bus.id_is_sc & (r_state == HZ_IDLE);
    assign io_bus.occupancy  = w_valid;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed scoreboard bench for decode_hazard_unit (LOAD_LAT=1 main DUT, LOAD_LAT=0 shadow).
module tb_decode_hazard_unit;

    localparam int DW = 32;
    localparam int NS = 3;

    localparam int S_RS     = 0;
    localparam int S_RT     = 1;
    localparam int S_STALL  = 2;
    localparam int S_ISSUE  = 3;
    localparam int S_ATOMIC = 4;
    localparam int S_SCMASK = 5;
    localparam int S_OCC    = 6;
    localparam int S_RS0    = 7;
    localparam int S_STALL0 = 8;
    localparam int S_NOTONE = 9;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    string       q_tag [$];
    int          q_sel [$];
    logic [31:0] q_exp [$];

    decode_hazard_unit_if #(.DATA_W(DW), .NUM_STAGES(NS)) bus ();
    decode_hazard_unit_if #(.DATA_W(DW), .NUM_STAGES(NS)) bus0 ();

    decode_hazard_unit #(.DATA_W(DW), .NUM_STAGES(NS), .LOAD_LAT(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    decode_hazard_unit #(.DATA_W(DW), .NUM_STAGES(NS), .LOAD_LAT(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus0)
    );

    // Shadow DUT sees identical stimulus
    assign bus0.id_valid          = bus.id_valid;
    assign bus0.id_rs_addr        = bus.id_rs_addr;
    assign bus0.id_rt_addr        = bus.id_rt_addr;
    assign bus0.id_reads_rs       = bus.id_reads_rs;
    assign bus0.id_reads_rt       = bus.id_reads_rt;
    assign bus0.id_reg_we         = bus.id_reg_we;
    assign bus0.id_reg_write_addr = bus.id_reg_write_addr;
    assign bus0.id_is_load        = bus.id_is_load;
    assign bus0.id_is_ll          = bus.id_is_ll;
    assign bus0.id_is_sc          = bus.id_is_sc;
    assign bus0.id_is_store       = bus.id_is_store;
    assign bus0.rf_rs_data        = bus.rf_rs_data;
    assign bus0.rf_rt_data        = bus.rf_rt_data;
    assign bus0.stage_data        = bus.stage_data;
    assign bus0.hold              = bus.hold;
    assign bus0.flush             = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RS:     return bus.rs_data;
            S_RT:     return bus.rt_data;
            S_STALL:  return 32'(bus.stall);
            S_ISSUE:  return 32'(bus.issue);
            S_ATOMIC: return 32'(bus.atomic_id);
            S_SCMASK: return 32'(bus.sc_mask_id);
            S_OCC:    return 32'(bus.occupancy);
            S_RS0:    return bus0.rs_data;
            S_STALL0: return 32'(bus0.stall);
            S_NOTONE: return 32'(bus.rs_data !== 32'h1);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(v);
    endtask

    task automatic check_all();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        while (q_sel.size() > 0) begin
            t = q_tag.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            o = observe(s);
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", t, o, e);
            end
        end
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rrs, input logic rrt, input logic we,
                         input logic [4:0] wa, input logic ld, input logic ll,
                         input logic sc, input logic st);
        bus.id_valid          = v;
        bus.id_rs_addr        = rs;
        bus.id_rt_addr        = rt;
        bus.id_reads_rs       = rrs;
        bus.id_reads_rt       = rrt;
        bus.id_reg_we         = we;
        bus.id_reg_write_addr = wa;
        bus.id_is_load        = ld;
        bus.id_is_ll          = ll;
        bus.id_is_sc          = sc;
        bus.id_is_store       = st;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_stage(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        bus.stage_data = {s2, s1, s0};
    endtask

    task automatic flush_cycle();
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.hold   = 1'b0;
        bus.flush  = 1'b0;
        bus.rf_rs_data = '0;
        bus.rf_rt_data = '0;
        set_stage(32'h0, 32'h0, 32'h0);
        idle();

        // reset state
        #1;
        expect_val("reset_occ",    S_OCC,    32'h0);
        expect_val("reset_stall",  S_STALL,  32'h0);
        expect_val("reset_issue",  S_ISSUE,  32'h0);
        expect_val("reset_atomic", S_ATOMIC, 32'h0);
        expect_val("reset_scmask", S_SCMASK, 32'h0);
        check_all();
        tick();
        tick();
        rst = 1'b0;

        // back-to-back ALU: addu $3 ; addu $4,$3,$0
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 0);
        expect_val("alu1_issue", S_ISSUE, 32'h1);
        expect_val("alu1_stall", S_STALL, 32'h0);
        settle();
        tick();
        drive(1, 5'd3, 5'd0, 1, 1, 1, 5'd4, 0, 0, 0, 0);
        bus.rf_rs_data = 32'hAAAA;
        bus.rf_rt_data = 32'h0;
        set_stage(32'h1234, 32'h0, 32'h0);
        expect_val("alu2_rs",    S_RS,    32'h1234);
        expect_val("alu2_rt",    S_RT,    32'h0);
        expect_val("alu2_stall", S_STALL, 32'h0);
        expect_val("alu2_occ",   S_OCC,   32'h1);
        settle();
        tick();
        bus.flush = 1'b1;
        expect_val("flush_issue", S_ISSUE, 32'h0);
        settle();
        tick();
        bus.flush = 1'b0;
        idle();
        expect_val("flush_occ", S_OCC, 32'h0);
        settle();

        // load-use: lw $5 ; addu $6,$5,$5
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0, 0, 0);
        expect_val("lw_issue", S_ISSUE, 32'h1);
        settle();
        tick();
        drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 0, 0, 0);
        bus.rf_rs_data = 32'h1111;
        bus.rf_rt_data = 32'h1111;
        set_stage(32'hBEEF, 32'hDEAD, 32'h0);
        expect_val("lu_stall", S_STALL, 32'h1);
        expect_val("lu_issue", S_ISSUE, 32'h0);
        settle();
        tick();
        expect_val("lu_occ",    S_OCC,   32'h2);
        expect_val("lu_stall2", S_STALL, 32'h0);
        expect_val("lu_rs",     S_RS,    32'hDEAD);
        expect_val("lu_rt",     S_RT,    32'hDEAD);
        expect_val("lu_issue2", S_ISSUE, 32'h1);
        settle();
        tick();
        flush_cycle();

        // youngest wins: addu $7 ; lw $7 ; read $7
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, 0, 0);
        expect_val("yw_alu_issue", S_ISSUE, 32'h1);
        settle();
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1, 0, 0, 0);
        tick();
        drive(1, 5'd7, 5'd0, 1, 0, 1, 5'd8, 0, 0, 0, 0);
        bus.rf_rs_data = 32'h2222;
        set_stage(32'h99, 32'h1, 32'h0);
        expect_val("yw_stall",   S_STALL,  32'h1);
        expect_val("yw_no_old",  S_NOTONE, 32'h1);
        expect_val("yw0_stall",  S_STALL0, 32'h0);
        expect_val("yw0_rs",     S_RS0,    32'h99);
        settle();
        tick();
        flush_cycle();

        // $zero destination and source
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0);
        expect_val("zero_issue", S_ISSUE, 32'h1);
        settle();
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd2, 0, 0, 0, 0);
        bus.rf_rs_data = 32'h0;
        bus.rf_rt_data = 32'h0;
        set_stage(32'h5555, 32'h0, 32'h0);
        expect_val("zero_occ",   S_OCC,   32'h0);
        expect_val("zero_rs",    S_RS,    32'h0);
        expect_val("zero_stall", S_STALL, 32'h0);
        settle();
        tick();
        flush_cycle();

        // ll ; sc
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 1, 0, 0);
        expect_val("ll_atomic_pre", S_ATOMIC, 32'h0);
        expect_val("ll_issue",      S_ISSUE,  32'h1);
        settle();
        tick();
        idle();
        expect_val("ll_atomic", S_ATOMIC, 32'h1);
        settle();
        drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        expect_val("sc_ok_mask",  S_SCMASK, 32'h0);
        expect_val("sc_ok_issue", S_ISSUE,  32'h1);
        settle();
        tick();
        idle();
        expect_val("sc_atomic_clr", S_ATOMIC, 32'h0);
        settle();

        // ll ; sw ; sc
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 1, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        expect_val("sw_atomic",  S_ATOMIC, 32'h0);
        expect_val("sc_fail_mask", S_SCMASK, 32'h1);
        settle();
        tick();

        // ll ; flush
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 1, 0, 0);
        tick();
        idle();
        expect_val("ll2_atomic", S_ATOMIC, 32'h1);
        settle();
        flush_cycle();
        expect_val("ll_flush_atomic", S_ATOMIC, 32'h0);
        settle();

        // fill, hold three cycles, then flush+hold
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd0, 5'd0, 0, 0, 1, 5'(11 + k), 0, 0, 0, 0);
            tick();
        end
        expect_val("fill_occ", S_OCC, 32'h7);
        settle();
        bus.hold = 1'b1;
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd14, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_val("hold_issue", S_ISSUE, 32'h0);
            settle();
            tick();
            expect_val("hold_occ", S_OCC, 32'h7);
            settle();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        idle();
        expect_val("flush_hold_occ", S_OCC, 32'h0);
        settle();

        // asynchronous reset in the middle of a load-use stall
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0, 0, 0);
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 0);
        expect_val("pre_rst_stall", S_STALL, 32'h1);
        settle();
        rst = 1'b1;
        #1;
        expect_val("async_rst_stall", S_STALL, 32'h0);
        expect_val("async_rst_occ",   S_OCC,   32'h0);
        check_all();
        tick();
        rst = 1'b0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_hazard_unit.md
Name: decode_hazard_unit

Overview:
- Parametrised hazard, forwarding and LL/SC reservation unit for the decode stage.
- Keeps a shift register of destination tags for in-flight instructions, one per downstream stage.
- Forwards operand data from the youngest matching stage, stalls when that data is not yet ready, and tracks the load-linked reservation.
- Replaces the fixed MEM-only forwarding and single EX load-use check in decode.

Parameters:
- DATA_W, 32, operand/result width
- NUM_STAGES, 3, tracked stages after decode (index 0 = EX, last = WB); >= 1
- LOAD_LAT, 1, stage index at which load data is valid; range 0..NUM_STAGES-1; 0 means no load-use stall

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_rs_addr  in  5  source register rs
- id_rt_addr  in  5  source register rt
- id_reads_rs  in  1  instruction consumes rs
- id_reads_rt  in  1  instruction consumes rt
- id_reg_we  in  1  instruction writes a register
- id_reg_write_addr  in  5  destination register
- id_is_load  in  1  LB/LBU/LW/LL
- id_is_ll  in  1  load-linked
- id_is_sc  in  1  store-conditional
- id_is_store  in  1  SB/SW (not SC)
- rf_rs_data  in  DATA_W  register file rs read
- rf_rt_data  in  DATA_W  register file rt read
- stage_data  in  NUM_STAGES*DATA_W  result per stage; slice i = stage i
- hold  in  1  global pipeline freeze
- flush  in  1  kill all in-flight entries and the decode instruction
- rs_data  out  DATA_W  forwarded rs operand
- rt_data  out  DATA_W  forwarded rt operand
- stall  out  1  decode must not issue this cycle
- issue  out  1  id_valid & ~stall & ~hold & ~flush
- atomic_id  out  1  reservation held
- sc_mask_id  out  1  current SC must not store
- occupancy  out  NUM_STAGES  valid bit of each tag entry (verification visibility)

Behaviour:
- Tag entry fields: valid, addr[4:0], is_load. The entry is ready at stage i when ~is_load or i >= LOAD_LAT.
- Reset: all entries invalid, reservation IDLE, occupancy 0. With no active input, outputs are stall=0, issue=0, atomic_id=0, sc_mask_id=0.
- Advance on each posedge when ~hold:
  - entry[i+1] <= entry[i]; the entry leaving the last stage is discarded.
  - entry[0] <= {issue & id_reg_we & (id_reg_write_addr != 0), id_reg_write_addr, id_is_load}.
  - A stall therefore inserts a bubble at stage 0.
- hold: all entries and the reservation are frozen. stall is still computed; issue=0.
- flush: on the next edge all entries become invalid and the reservation goes to IDLE. flush takes priority over hold. issue=0 during the flush cycle.
- Match for stage i and source s: entry[i].valid & entry[i].addr == s_addr & s_addr != 0.
- Forwarding (combinational, zero latency):
  - The lowest matching index wins.
  - If that entry is ready, the operand is stage_data slice i; otherwise the operand is a don't-care.
  - With no match, the operand is the rf data.
  - An older ready match never overrides a younger unready one.
- stall = id_valid & ((reads_rs & youngest rs match unready) | (reads_rt & youngest rt match unready)).
- A write by the last stage is visible in rf_*_data in the same cycle; the register file writes before it reads.
- Reservation FSM, states IDLE / RESERVED, updated only on an issue cycle:
  - ll → RESERVED
  - store or sc → IDLE
  - ll has priority if flags conflict
- atomic_id = (state == RESERVED).
- sc_mask_id = id_is_sc & (state == IDLE). This is combinational and meaningful in the issue cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). No output is registered except occupancy and atomic_id.

Decomposition:
- mips_defines.v gains `HZ_IDLE / `HZ_RESERVED state encodings and the tag-entry field widths. `ZERO is reused.
- Sub-module hazard_tag_pipe holds the NUM_STAGES tag shift register, including hold/flush/bubble insertion, and exposes the flat valid/addr/ready vectors.
- Match, priority select and the FSM stay in the top module.

Test Plan:
- Back-to-back ALU ops: addu $3 then addu $4,$3,$0 with stage_data[0]=0x1234 → rs_data=0x1234, stall=0.
- Load-use with LOAD_LAT=1: lw $5 then addu $6,$5,$5 → stall=1 for one cycle, occupancy=3'b010 afterwards; the next cycle forwards slice 1 = 0xDEAD on both operands, stall=0.
- Youngest-wins: addu $7 (slice 1 = 0x1) followed by lw $7 (slice 0, unready) → stall=1, with no forwarding of 0x1. With LOAD_LAT=0, rs_data = slice 0.
- $zero: destination $0 then a read of $0 → rs_data=rf_rs_data=0, stall=0, occupancy[0]=0.
- LL/SC: ll → atomic_id=1 next cycle; sc → sc_mask_id=0. ll, sw, sc → sc_mask_id=1. ll then flush → atomic_id=0.
- hold plus flush: hold for 3 cycles freezes occupancy=3'b111. Asserting flush and hold together clears occupancy to 0 next edge. Asynchronous rst mid-stall clears stall within the same cycle.
